// File: rtl/dmem_arbiter.sv
// ============================================================================
//  dmem_arbiter
//  Shares one data-RAM port between a CPU port (fixed priority) and a DMA
//  port protected by a starvation counter; routes read data back one cycle later.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [2:0]        cpu_access_type,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic [2:0]        dma_access_type,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   // RAM port
   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   output logic [2:0]        ram_access_type,
   input  logic [DATA_W-1:0] ram_dataOut
);

   localparam int               CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             rd_pend_q,  rd_pend_d;
   logic             rd_sel_q,   rd_sel_d;

   // Grant: a starved DMA request overrides CPU priority.
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (dma_req && (wait_cnt_q == C_MAX)) begin
            dma_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (dma_req) begin
            dma_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr        = cpu_addr;
      ram_dataIn      = cpu_wdata;
      ram_access_type = cpu_access_type;
      ram_wEn         = cpu_gnt & cpu_we;
      if (dma_gnt) begin
         ram_addr        = dma_addr;
         ram_dataIn      = dma_wdata;
         ram_access_type = dma_access_type;
         ram_wEn         = dma_we;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (dma_gnt || !dma_req) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != C_MAX) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // rd_sel only matters while rd_pend is set, so it holds otherwise.
   always_comb begin
      rd_pend_d = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
      rd_sel_d  = rd_pend_d ? dma_gnt : rd_sel_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_sel_q   <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_sel_q   <= rd_sel_d;
      end
   end

   assign cpu_rvalid = rd_pend_q & ~rd_sel_q;
   assign dma_rvalid = rd_pend_q &  rd_sel_q;
   assign cpu_rdata  = ram_dataOut;
   assign dma_rdata  = ram_dataOut;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  tb_dmem_arbiter
//  Scenario-per-task bench with a read-response scoreboard and a RAM model.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic [2:0]        cpu_access_type;
   logic              dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata, dma_rdata;
   logic [2:0]        dma_access_type;
   logic              ram_wEn;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dataIn, ram_dataOut;
   logic [2:0]        ram_access_type;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_access_type(cpu_access_type), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_access_type(dma_access_type), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata),
      .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
      .ram_access_type(ram_access_type), .ram_dataOut(ram_dataOut)
   );

   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'hA5000000 ^ (i * 32'h00010003);
   endfunction

   // Synchronous RAM: read data appears the cycle after the address.
   logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];
   logic              preload;

   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < (1<<ADDR_W); i++) mem[i] <= init_val(i);
      end else begin
         if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      end
      ram_dataOut <= mem[ram_addr];
   end

   typedef struct {
      int                cyc;
      bit                port;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Response scoreboard: an entry pushed in cycle N must be answered in N+1.
   always @(negedge clock) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
            mon_e = sb.pop_front();
            n_vec++; n_fail++;
            $display("FAIL rsp_missing: read from cycle %0d never answered, want port %0d data %h",
                     mon_e.cyc, mon_e.port, mon_e.data);
         end
         n_vec++;
         if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
            mon_e = sb.pop_front();
            if ({cpu_rvalid, dma_rvalid} !== (mon_e.port ? 2'b01 : 2'b10) ||
                (mon_e.port ? dma_rdata : cpu_rdata) !== mon_e.data) begin
               n_fail++;
               $display("FAIL rsp cyc %0d: cpu_rvalid=%b dma_rvalid=%b rdata=%h, want port %0d data %h",
                        cyc, cpu_rvalid, dma_rvalid, mon_e.port ? dma_rdata : cpu_rdata,
                        mon_e.port, mon_e.data);
            end
         end else if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_spurious cyc %0d: cpu_rvalid=%b dma_rvalid=%b, want 0 0",
                     cyc, cpu_rvalid, dma_rvalid);
         end
      end
   end

   task automatic drive(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input logic [2:0] ct,
                        input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dd, input logic [2:0] dt);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_access_type = ct;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_access_type = dt;
   endtask

   task automatic idle();
      drive(0, 0, '0, '0, 3'b000, 0, 0, '0, '0, 3'b000);
   endtask

   // Update the bench memory model / scoreboard from the grant the bench expects.
   task automatic model_grant(input bit cg, input bit dg);
      exp_t e;
      if (cg) begin
         if (cpu_we) exp_mem[cpu_addr] = cpu_wdata;
         else begin e.cyc = cyc; e.port = 1'b0; e.data = exp_mem[cpu_addr]; sb.push_back(e); end
      end
      if (dg) begin
         if (dma_we) exp_mem[dma_addr] = dma_wdata;
         else begin e.cyc = cyc; e.port = 1'b1; e.data = exp_mem[dma_addr]; sb.push_back(e); end
      end
   endtask

   task automatic next_cycle();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1, 1, 12'h020, 32'h0BADF00D, 3'b010, 1, 0, 12'h021, '0, 3'b010);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid, dma_rvalid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b%b wEn=%b rvalid=%b%b, want all 0",
                  cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid, dma_rvalid);
      end
      next_cycle();
      reset = 1'b0;
      idle();
      @(negedge clock);
      n_vec++;
      if (dut.wait_cnt_q !== 3'd0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: wait_cnt=%0d rvalid=%b%b, want 0 0 0",
                  dut.wait_cnt_q, cpu_rvalid, dma_rvalid);
      end
      n_vec++;
      if (mem[12'h020] !== exp_mem[12'h020]) begin
         n_fail++;
         $display("FAIL reset_no_write: mem[020]=%h want %h", mem[12'h020], exp_mem[12'h020]);
      end
      mon_en = 1'b1;
      next_cycle();
   endtask

   task automatic test_cpu_read();
      drive(1, 0, 12'h010, '0, 3'b010, 0, 0, '0, '0, 3'b000);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn} !== 3'b100 || ram_addr !== 12'h010) begin
         n_fail++;
         $display("FAIL cpu_read_gnt: gnt=%b%b wEn=%b addr=%h, want 1 0 0 010",
                  cpu_gnt, dma_gnt, ram_wEn, ram_addr);
      end
      model_grant(1, 0);
      next_cycle();
      idle();
      @(negedge clock);
      n_vec++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL cpu_read_rsp: rvalid=%b%b rdata=%h, want 1 0 deadbeef",
                  cpu_rvalid, dma_rvalid, cpu_rdata);
      end
      next_cycle();
   endtask

   task automatic test_dma_write();
      drive(0, 0, '0, '0, 3'b000, 1, 1, 12'h3FF, 32'h12345678, 3'b010);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn} !== 3'b011 || ram_addr !== 12'h3FF ||
          ram_dataIn !== 32'h12345678 || ram_access_type !== 3'b010) begin
         n_fail++;
         $display("FAIL dma_write: gnt=%b%b wEn=%b addr=%h din=%h type=%b, want 0 1 1 3ff 12345678 010",
                  cpu_gnt, dma_gnt, ram_wEn, ram_addr, ram_dataIn, ram_access_type);
      end
      model_grant(0, 1);
      next_cycle();
      // Read back through DMA; the idle-cycle "no rvalid" check is done by the scoreboard.
      drive(0, 0, '0, '0, 3'b000, 1, 0, 12'h3FF, '0, 3'b010);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid} !== 4'b0100) begin
         n_fail++;
         $display("FAIL dma_readback_gnt: gnt=%b%b rvalid=%b%b, want 0 1 0 0",
                  cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid);
      end
      model_grant(0, 1);
      next_cycle();
      idle();
      next_cycle();
   endtask

   task automatic test_starvation();
      logic [ADDR_W-1:0] da = 12'h200;
      bit exp_d;
      for (int i = 0; i < 15; i++) begin
         drive(1, 0, 12'(32'h100 + i), '0, 3'b010, 1, 0, da, '0, 3'b001);
         @(negedge clock);
         exp_d = ((i % 5) == 4);
         n_vec++;
         if ({cpu_gnt, dma_gnt} !== {~exp_d, exp_d}) begin
            n_fail++;
            $display("FAIL starve_gnt[%0d]: gnt=%b%b want %b%b", i, cpu_gnt, dma_gnt, ~exp_d, exp_d);
         end
         n_vec++;
         if (dut.wait_cnt_q !== 3'(i % 5)) begin
            n_fail++;
            $display("FAIL starve_wait[%0d]: wait_cnt=%0d want %0d", i, dut.wait_cnt_q, i % 5);
         end
         model_grant(~exp_d, exp_d);
         if (exp_d) da = da + 12'd1;
         next_cycle();
      end
      idle();
      next_cycle();
   endtask

   task automatic test_interleave();
      drive(1, 0, 12'h001, '0, 3'b010, 0, 0, '0, '0, 3'b000);
      @(negedge clock);
      model_grant(1, 0);
      next_cycle();
      drive(0, 0, '0, '0, 3'b000, 1, 0, 12'h002, '0, 3'b010);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid} !== 4'b0110 || cpu_rdata !== exp_mem[12'h001]) begin
         n_fail++;
         $display("FAIL interleave_c2: gnt=%b%b rvalid=%b%b rdata=%h, want 0 1 1 0 %h",
                  cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_rdata, exp_mem[12'h001]);
      end
      model_grant(0, 1);
      next_cycle();
      idle();
      @(negedge clock);
      n_vec++;
      if ({cpu_rvalid, dma_rvalid} !== 2'b01 || dma_rdata !== exp_mem[12'h002]) begin
         n_fail++;
         $display("FAIL interleave_c3: rvalid=%b%b rdata=%h, want 0 1 %h",
                  cpu_rvalid, dma_rvalid, dma_rdata, exp_mem[12'h002]);
      end
      next_cycle();
   endtask

   task automatic test_counter_clear();
      int exp_w [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};
      bit dr, exp_d;
      for (int i = 0; i < 9; i++) begin
         dr    = (i != 3);
         exp_d = (i == 8);
         drive(1, 0, 12'(32'h180 + i), '0, 3'b000, dr, 1, 12'h300, 32'hC0DE0300, 3'b010);
         @(negedge clock);
         n_vec++;
         if ({cpu_gnt, dma_gnt} !== {~exp_d, exp_d} || dut.wait_cnt_q !== 3'(exp_w[i])) begin
            n_fail++;
            $display("FAIL clear[%0d]: gnt=%b%b wait_cnt=%0d, want %b%b %0d",
                     i, cpu_gnt, dma_gnt, dut.wait_cnt_q, ~exp_d, exp_d, exp_w[i]);
         end
         model_grant(~exp_d, exp_d);
         next_cycle();
      end
      drive(0, 0, '0, '0, 3'b000, 1, 0, 12'h300, '0, 3'b010);
      @(negedge clock);
      model_grant(0, 1);
      next_cycle();
      idle();
      next_cycle();
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      drive(1, 1, 12'h020, 32'hFEEDFACE, 3'b010, 0, 0, '0, '0, 3'b000);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_write_gnt: gnt=%b%b wEn=%b, want 0 0 0", cpu_gnt, dma_gnt, ram_wEn);
      end
      next_cycle();
      reset = 1'b0;
      drive(1, 0, 12'h010, '0, 3'b010, 0, 0, '0, '0, 3'b000);
      @(negedge clock);
      n_vec++;
      if (mem[12'h020] !== exp_mem[12'h020] || cpu_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_write_blocked: mem[020]=%h gnt=%b, want %h 1", mem[12'h020], cpu_gnt, exp_mem[12'h020]);
      end
      model_grant(1, 0);
      next_cycle();
      reset = 1'b1;
      drive(1, 0, 12'h011, '0, 3'b010, 1, 1, 12'h012, 32'h1, 3'b010);
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid} !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_after_read: gnt=%b%b wEn=%b cpu_rvalid=%b, want 0 0 0 1",
                  cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid);
      end
      next_cycle();
      @(negedge clock);
      n_vec++;
      if ({cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid, dma_rvalid} !== 5'b0 || dut.wait_cnt_q !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_hold: gnt=%b%b wEn=%b rvalid=%b%b wait_cnt=%0d, want all 0",
                  cpu_gnt, dma_gnt, ram_wEn, cpu_rvalid, dma_rvalid, dut.wait_cnt_q);
      end
      next_cycle();
      reset = 1'b0;
      idle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         if (i == 4)      drive(1, 1, 12'h055, 32'h5A5A0055, 3'b010, 0, 0, '0, '0, 3'b000);
         else if (i == 5) drive(1, 0, 12'h055, '0, 3'b010, 0, 0, '0, '0, 3'b000);
         else             drive(1, 0, 12'(32'h040 + i), '0, 3'b010, 0, 0, '0, '0, 3'b000);
         @(negedge clock);
         n_vec++;
         if ({cpu_gnt, dma_gnt} !== 2'b10 || ram_wEn !== (i == 4)) begin
            n_fail++;
            $display("FAIL b2b[%0d]: gnt=%b%b wEn=%b, want 1 0 %b", i, cpu_gnt, dma_gnt, ram_wEn, i == 4);
         end
         model_grant(1, 0);
         next_cycle();
      end
      idle();
      next_cycle();
      next_cycle();
   endtask

   initial begin
      reset   = 1'b1;
      preload = 1'b1;
      idle();
      for (int i = 0; i < (1<<ADDR_W); i++) exp_mem[i] = init_val(i);
      next_cycle();
      preload = 1'b0;

      test_reset();
      test_cpu_read();
      test_dma_write();
      test_starvation();
      test_interleave();
      test_counter_clear();
      test_reset_mid();
      test_back_to_back();

      n_vec++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
